ldr_str_unit: RTL



---
 rtl/ldr_str_unit.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ldr_str_unit.sv
// -----------------------------------------------------------------------------
// ldr_str_unit
//
// Load/store unit between the CPU datapath and a word-addressed memory with a
// request/acknowledge handshake. One transaction is in flight at a time:
//   IDLE  - req_ready high. An accepted request has its fields latched.
//   ISSUE - mem_req held high with stable mem_we/mem_addr/mem_wdata/mem_be
//           until mem_ack or until ACK_TIMEOUT cycles pass without one.
//   WB    - one cycle of register-file writeback for a completed load.
//
// Parameters
//   MEM_ADDR_W   memory word-address width (default 11)
//   ACK_TIMEOUT  ISSUE cycles without mem_ack before abort (1..255, default 15)
//
// Optional feature (compile-time macro LSU_BYTE_ACCESS_EN)
//   Defined:   req_byte port present. Byte stores drive a one-hot mem_be from
//              addr[1:0] and replicate the low data byte on all four lanes.
//              Byte loads also drive the one-hot lane enable, and zero-extend
//              the byte picked by addr[1:0]. Byte accesses never flag
//              misalignment.
//   Undefined: req_byte absent. Every access is a full word with mem_be = 4'hF.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    datapath request handshake (ready only in IDLE)
//   req_load           1 = LDR, 0 = STR
//   req_byte           byte access (LSU_BYTE_ACCESS_EN only)
//   req_addr/wdata/rd  byte address, store data, load destination register
//   mem_req/we/addr/wdata/be, mem_ack, mem_rdata   memory interface
//   w_data_ldr/w_addr_ldr/w_en_ldr   register-file load writeback (WB only)
//   ldr_pending, pend_rd             outstanding-load hazard information
//   align_err          pulse: misaligned word access accepted
//   mem_timeout        pulse: transaction aborted for lack of mem_ack
// -----------------------------------------------------------------------------
module ldr_str_unit #(
  parameter int unsigned MEM_ADDR_W  = 11,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
`ifdef LSU_BYTE_ACCESS_EN
  input  logic                  req_byte,
`endif
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           w_data_ldr,
  output logic [3:0]            w_addr_ldr,
  output logic                  w_en_ldr,
  output logic                  ldr_pending,
  output logic [3:0]            pend_rd,
  output logic                  align_err,
  output logic                  mem_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WB
  } state_e;

  // Counter value seen in the last ISSUE cycle allowed to go without mem_ack.
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e                  state_q;
  logic [7:0]              cnt_q;
  logic                    load_q;
  logic                    byte_q;
  logic [1:0]              offs_q;
  logic [3:0]              rd_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [MEM_ADDR_W-1:0]   mem_addr_q;
  logic [31:0]             mem_wdata_q;
  logic [3:0]              mem_be_q;
  logic                    w_en_q;
  logic [3:0]              w_addr_q;
  logic [31:0]             w_data_q;
  logic                    ldr_pending_q;
  logic [3:0]              pend_rd_q;
  logic                    align_err_q;
  logic                    mem_timeout_q;

  logic                    req_is_byte;
  logic [3:0]              be_d;
  logic [31:0]             wdata_d;
  logic [31:0]             rdata_d;
  logic                    misalign_d;
  logic                    transfer;

`ifdef LSU_BYTE_ACCESS_EN
  assign req_is_byte = req_byte;
`else
  assign req_is_byte = 1'b0;
`endif

  // Address bits above the memory word address are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_ADDR_W+2];

  // req_ready also depends on rst so it reads 0 throughout reset yet is 1 in
  // the very first cycle after rst falls.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign transfer  = req_valid && req_ready;

  assign misalign_d = !req_is_byte && (req_addr[1:0] != 2'b00);

  // Request formatting: lane enables and store data as presented to memory.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    be_d    = 4'hF;
    wdata_d = req_wdata;
    if (req_is_byte) begin
      be_d    = 4'b0001 << req_addr[1:0];
      wdata_d = {4{req_wdata[7:0]}};
    end
  end

  // Load data: whole word, or the addressed byte zero-extended.
  always_comb begin
    rdata_d = mem_rdata;
    if (byte_q) begin
      case (offs_q)
        2'd0:    rdata_d = {24'h0, mem_rdata[7:0]};
        2'd1:    rdata_d = {24'h0, mem_rdata[15:8]};
        2'd2:    rdata_d = {24'h0, mem_rdata[23:16]};
        default: rdata_d = {24'h0, mem_rdata[31:24]};
      endcase
    end
  end

  // Control FSM with registered outputs.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is synchronous; every latched field is cleared as well so
      // nothing from an abandoned transaction leaks onto the outputs.
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      load_q        <= 1'b0;
      byte_q        <= 1'b0;
      offs_q        <= '0;
      rd_q          <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      w_en_q        <= 1'b0;
      w_addr_q      <= '0;
      w_data_q      <= '0;
      ldr_pending_q <= 1'b0;
      pend_rd_q     <= '0;
      align_err_q   <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      align_err_q   <= 1'b0;
      mem_timeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (transfer) begin
            load_q        <= req_load;
            byte_q        <= req_is_byte;
            offs_q        <= req_addr[1:0];
            rd_q          <= req_rd;
            mem_we_q      <= !req_load;
            mem_addr_q    <= req_addr[MEM_ADDR_W+1:2];
            mem_wdata_q   <= wdata_d;
            mem_be_q      <= be_d;
            mem_req_q     <= 1'b1;
            cnt_q         <= '0;
            ldr_pending_q <= req_load;
            pend_rd_q     <= req_load ? req_rd : 4'd0;
            align_err_q   <= misalign_d;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            if (load_q) begin
              w_en_q   <= 1'b1;
              w_addr_q <= rd_q;
              w_data_q <= rdata_d;
              state_q  <= S_WB;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (cnt_q == CNT_LAST) begin
            // Give up: no writeback, the pending load is dropped.
            mem_req_q     <= 1'b0;
            cnt_q         <= '0;
            mem_timeout_q <= 1'b1;
            ldr_pending_q <= 1'b0;
            pend_rd_q     <= '0;
            state_q       <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WB: begin
          w_en_q        <= 1'b0;
          w_addr_q      <= '0;
          w_data_q      <= '0;
          ldr_pending_q <= 1'b0;
          pend_rd_q     <= '0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign w_en_ldr    = w_en_q;
  assign w_addr_ldr  = w_addr_q;
  assign w_data_ldr  = w_data_q;
  assign ldr_pending = ldr_pending_q;
  assign pend_rd     = pend_rd_q;
  assign align_err   = align_err_q;
  assign mem_timeout = mem_timeout_q;

endmodule
